sdram_model_ram: RTL and testbench
==================================

# sdram_model_ram

Block-RAM-backed responder for the SDRAM controller's logical port: same port names, handshake, and observable timing (idle, access, ack, refresh inhibit, read pause). Used in place of the real controller in demos and benches so that initiators such as the fill/readback test logic and the UART dump path can be brought up without external SDRAM. Models power-up delay, access latency and periodic refresh so that initiator stall handling is exercised.

## Interface
- ADDR_WIDTH, 24, byte address width of `adr_i`; word index = `adr_i[ADDR_WIDTH-1:1]`
- DATA_WIDTH, 16, data width (two byte lanes)
- MEM_WORDS_LOG2, 12, stored depth in words; word index truncated to its low MEM_WORDS_LOG2 bits (upper addresses alias)
- INIT_CYCLES, 16, post-reset busy time before first idle
- READ_LATENCY, 5, cycles from accepted access to read ack (>=1)
- WRITE_LATENCY, 3, cycles from accepted access to write ack (>=1)
- REFRESH_INTERVAL, 1000, cycles between refresh requests
- REFRESH_CYCLES, 7, duration of one refresh

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- adr_i  in  ADDR_WIDTH  byte address, sampled on acceptance
- dat_i  in  DATA_WIDTH  write data, sampled on acceptance
- sel_i  in  2  byte enables: [1] upper byte, [0] lower byte; writes only
- we_i  in  1  1 = write, 0 = read; sampled on acceptance
- acc_i  in  1  access request, level, held until ack
- refresh_inhibit_i  in  1  defers pending refresh while high
- pause_read_i  in  1  holds a due read ack while high
- idle_o  out  1  high when in IDLE and able to accept
- ack_raw  out  1  one-cycle completion pulse
- dat_raw  out  DATA_WIDTH  last read data, held until next read completes
- refresh_count_o  out  16  number of refreshes performed, wraps

## Operation
- States: INIT, IDLE, BUSY, RECOVER, REFRESH.
- Reset (async, reset_n low): state INIT, idle_o=0, ack_raw=0, dat_raw=0, refresh_count_o=0, refresh timer=0, refresh pending=0. Memory contents are not reset. An access in flight is abandoned; no ack is issued and no write is committed.
- INIT: count INIT_CYCLES cycles, then IDLE. The refresh timer is held at 0 during INIT.
- IDLE: idle_o=1.
  - Pending refresh with refresh_inhibit_i low: enter REFRESH. Refresh has priority over a simultaneous acc_i.
  - Otherwise, if acc_i is high: latch adr_i, dat_i, sel_i and we_i, load the latency counter, and enter BUSY.
- BUSY: decrement the latency counter to 0.
  - Write, at 0: commit enabled byte lanes to the latched word, pulse ack_raw, enter RECOVER.
  - Read, at 0 with pause_read_i low: load dat_raw from memory, pulse ack_raw, enter RECOVER.
  - Read, at 0 with pause_read_i high: stay in BUSY at 0 until pause_read_i goes low.
- RECOVER: wait until acc_i is sampled low (minimum 1 cycle), then IDLE. A request still held high after its ack is never re-serviced.
- REFRESH: clear pending, count REFRESH_CYCLES cycles, increment refresh_count_o, then IDLE.
- Refresh timer: free-runs after INIT. When it reaches REFRESH_INTERVAL-1 it sets pending (sticky) and wraps to 0. The inhibit only defers the refresh; a second expiry while already pending is absorbed (one refresh, not two). Pending is not acted on mid-access; it is serviced at the next IDLE.
- Read ignores sel_i. Addresses at or above 2^MEM_WORDS_LOG2 words alias.

## Timing
- Access accepted at edge E (IDLE, acc_i=1): ack_raw is high in the cycle following edge E+READ_LATENCY for reads or E+WRITE_LATENCY for writes, plus any pause cycles.
- dat_raw changes only in the ack cycle and is valid in that cycle; the memory write is visible to a read accepted afterwards.
- idle_o falls in the cycle after acceptance and rises no earlier than 2 cycles after ack: back-to-back throughput is latency + 2.
- ack_raw is high for exactly one cycle per access.

## Test plan
- Reset, then hold acc_i low: idle_o=0 for 16 cycles, then 1; refresh_count_o=0; dat_raw=0.
- Write 0x3041 to address 0x000002 with sel=11, then read it: read ack 5 cycles after acceptance, dat_raw=0x3041, one-cycle ack pulses; write ack 3 cycles after acceptance.
- Write 0xFFFF, then 0x1234 with sel=01, then read: 0xFF34. Read address 0x002002 (alias with MEM_WORDS_LOG2=12): returns the word at 0x000002.
- Hold refresh_inhibit_i=1 across 2500 cycles: refresh_count_o stays 0. Release it: exactly one refresh (idle_o low 7 cycles), refresh_count_o=1.
- Read with pause_read_i held high 20 cycles: ack is delayed until the cycle after release. acc_i held high 3 cycles past ack: no second ack.
- Assert reset_n low mid-write: no ack. The target word is unchanged on readback after INIT.

Source files
------------

// File: rtl/sdram_model_ram.sv
// Block-RAM stand-in for the SDRAM controller's logical port. It reproduces the
// controller's handshake, power-up delay, access latency and periodic refresh.
module sdram_model_ram #(
  parameter int ADDR_WIDTH       = 24,
  parameter int DATA_WIDTH       = 16,
  parameter int MEM_WORDS_LOG2   = 12,
  parameter int INIT_CYCLES      = 16,
  parameter int READ_LATENCY     = 5,
  parameter int WRITE_LATENCY    = 3,
  parameter int REFRESH_INTERVAL = 1000,
  parameter int REFRESH_CYCLES   = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [1:0]            sel_i,
  input  logic                  we_i,
  input  logic                  acc_i,
  input  logic                  refresh_inhibit_i,
  input  logic                  pause_read_i,
  output logic                  idle_o,
  output logic                  ack_raw,
  output logic [DATA_WIDTH-1:0] dat_raw,
  output logic [15:0]           refresh_count_o
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_RECOVER,
    S_REFRESH
  } state_e;

  localparam logic [15:0] INIT_LAST    = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] RD_LAT_LOAD  = 16'(READ_LATENCY - 1);
  localparam logic [15:0] WR_LAT_LOAD  = 16'(WRITE_LATENCY - 1);
  localparam logic [15:0] RTMR_LAST    = 16'(REFRESH_INTERVAL - 1);
  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_CYCLES - 1);

  typedef logic [MEM_WORDS_LOG2-1:0] widx_t;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           rtmr_q, rtmr_d;
  logic                  pend_q, pend_d;
  logic                  we_q, we_d;
  logic [1:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  widx_t                 widx_q, widx_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_raw_q, dat_raw_d;
  logic [15:0]           rcount_q, rcount_d;
  logic                  pend_set, pend_clr;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_WORDS_LOG2)-1];
  logic [DATA_WIDTH-1:0] rd_q;

  // Byte-offset bit and the aliased upper word bits are intentionally dropped.
  logic adr_unused;
  assign adr_unused = ^{adr_i[0], adr_i[ADDR_WIDTH-1:MEM_WORDS_LOG2+1]};

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rtmr_d    = rtmr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    widx_d    = widx_q;
    ack_d     = 1'b0;
    dat_raw_d = dat_raw_q;
    rcount_d  = rcount_q;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    mem_we    = 1'b0;

    if (state_q == S_INIT) begin
      rtmr_d = '0;
    end else if (rtmr_q == RTMR_LAST) begin
      rtmr_d   = '0;
      pend_set = 1'b1;
    end else begin
      rtmr_d = rtmr_q + 16'd1;
    end

    unique case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (pend_q && !refresh_inhibit_i) begin
          state_d  = S_REFRESH;
          cnt_d    = '0;
          pend_clr = 1'b1;
        end else if (acc_i) begin
          state_d = S_BUSY;
          we_d    = we_i;
          sel_d   = sel_i;
          dat_d   = dat_i;
          widx_d  = adr_i[MEM_WORDS_LOG2:1];
          cnt_d   = we_i ? WR_LAT_LOAD : RD_LAT_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (we_q) begin
          mem_we  = 1'b1;
          ack_d   = 1'b1;
          state_d = S_RECOVER;
        end else if (!pause_read_i) begin
          dat_raw_d = rd_q;
          ack_d     = 1'b1;
          state_d   = S_RECOVER;
        end
      end
      S_RECOVER: begin
        // A request still held after its ack must not be taken again.
        if (!acc_i) state_d = S_IDLE;
      end
      S_REFRESH: begin
        if (cnt_q == REFRESH_LAST) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          rcount_d = rcount_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_INIT;
    endcase

    // A timer expiry landing on the refresh-entry edge keeps the request alive.
    pend_d = pend_set | (pend_q & ~pend_clr);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      rtmr_q    <= '0;
      pend_q    <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      widx_q    <= '0;
      ack_q     <= 1'b0;
      dat_raw_q <= '0;
      rcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rtmr_q    <= rtmr_d;
      pend_q    <= pend_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      widx_q    <= widx_d;
      ack_q     <= ack_d;
      dat_raw_q <= dat_raw_d;
      rcount_q  <= rcount_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; the read
  // register is loaded while idle, so it already holds the word at acceptance.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (sel_q[0]) mem[widx_q][7:0]            <= dat_q[7:0];
      if (sel_q[1]) mem[widx_q][DATA_WIDTH-1:8] <= dat_q[DATA_WIDTH-1:8];
    end
    if (state_q == S_IDLE) rd_q <= mem[adr_i[MEM_WORDS_LOG2:1]];
  end

  assign idle_o          = (state_q == S_IDLE);
  assign ack_raw         = ack_q;
  assign dat_raw         = dat_raw_q;
  assign refresh_count_o = rcount_q;

endmodule

// File: tb/tb_sdram_model_ram.sv
// Directed bench for sdram_model_ram: init delay, latency, byte lanes, aliasing,
// read pause, refresh inhibit and reset abandoning a write.
module tb_sdram_model_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] adr_i;
  logic [15:0] dat_i;
  logic [1:0]  sel_i;
  logic        we_i;
  logic        acc_i;
  logic        refresh_inhibit_i;
  logic        pause_read_i;
  logic        idle_o;
  logic        ack_raw;
  logic [15:0] dat_raw;
  logic [15:0] refresh_count_o;

  int vectors     = 0;
  int miscompares = 0;

  sdram_model_ram dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .adr_i            (adr_i),
    .dat_i            (dat_i),
    .sel_i            (sel_i),
    .we_i             (we_i),
    .acc_i            (acc_i),
    .refresh_inhibit_i(refresh_inhibit_i),
    .pause_read_i     (pause_read_i),
    .idle_o           (idle_o),
    .ack_raw          (ack_raw),
    .dat_raw          (dat_raw),
    .refresh_count_o  (refresh_count_o)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!idle_o && n < 60) begin
      step();
      n++;
    end
    check({tag, "_idle_wait"}, {31'd0, idle_o}, 32'd1);
  endtask

  // One access: checks latency, single-cycle ack and return to idle.
  task automatic access(input string tag, input logic we, input logic [23:0] adr,
                        input logic [15:0] dat, input logic [1:0] sel, input int exp_lat);
    int n = 0;
    wait_idle(tag);
    adr_i = adr; dat_i = dat; sel_i = sel; we_i = we; acc_i = 1'b1;
    step();
    check({tag, "_busy"}, {31'd0, idle_o}, 32'd0);
    do begin
      step();
      n++;
    end while (!ack_raw && n < 40);
    check({tag, "_latency"}, n, exp_lat);
    acc_i = 1'b0;
    step();
    check({tag, "_ack_pulse"}, {31'd0, ack_raw}, 32'd0);
    check({tag, "_idle_back"}, {31'd0, idle_o}, 32'd1);
  endtask

  initial begin
    int acks;
    int n;
    reset_n = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0; we_i = 1'b0;
    acc_i = 1'b0; refresh_inhibit_i = 1'b0; pause_read_i = 1'b0;
    step(); step();
    check("rst_idle", {31'd0, idle_o}, 32'd0);
    check("rst_ack", {31'd0, ack_raw}, 32'd0);
    check("rst_dat", {16'd0, dat_raw}, 32'd0);
    check("rst_rcount", {16'd0, refresh_count_o}, 32'd0);

    // Power-up: 16 low samples, then idle.
    reset_n = 1'b1;
    check("init_idle_0", {31'd0, idle_o}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      step();
      check($sformatf("init_idle_%0d", i), {31'd0, idle_o}, 32'd0);
    end
    step();
    check("init_done", {31'd0, idle_o}, 32'd1);

    access("wr3041", 1'b1, 24'h000002, 16'h3041, 2'b11, 3);
    check("wr_keeps_dat", {16'd0, dat_raw}, 32'd0);
    access("rd3041", 1'b0, 24'h000002, 16'h0000, 2'b00, 5);
    check("rd3041_data", {16'd0, dat_raw}, 32'h3041);

    access("wrFFFF", 1'b1, 24'h000002, 16'hFFFF, 2'b11, 3);
    access("wr1234_lo", 1'b1, 24'h000002, 16'h1234, 2'b01, 3);
    check("wr_holds_dat", {16'd0, dat_raw}, 32'h3041);
    access("rd_merge", 1'b0, 24'h000002, 16'h0000, 2'b10, 5);
    check("rd_merge_data", {16'd0, dat_raw}, 32'hFF34);
    access("wr_other", 1'b1, 24'h000004, 16'h5A5A, 2'b11, 3);
    access("rd_alias", 1'b0, 24'h002002, 16'h0000, 2'b00, 5);
    check("rd_alias_data", {16'd0, dat_raw}, 32'hFF34);

    // Read held by pause for 20 cycles, request held 3 cycles past ack.
    access("rd_other", 1'b0, 24'h000004, 16'h0000, 2'b00, 5);
    check("rd_other_data", {16'd0, dat_raw}, 32'h5A5A);
    wait_idle("pause");
    adr_i = 24'h000002; we_i = 1'b0; acc_i = 1'b1; pause_read_i = 1'b1;
    step();
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_raw) acks++;
    end
    check("pause_no_ack", acks, 0);
    check("pause_dat_held", {16'd0, dat_raw}, 32'h5A5A);
    pause_read_i = 1'b0;
    step();
    check("pause_release_ack", {31'd0, ack_raw}, 32'd1);
    check("pause_data", {16'd0, dat_raw}, 32'hFF34);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack_raw || idle_o) acks++;
    end
    check("held_req_no_reservice", acks, 0);
    acc_i = 1'b0;
    step();
    check("held_req_idle", {31'd0, idle_o}, 32'd1);

    // Reset two cycles into a write abandons it.
    wait_idle("rstwr");
    adr_i = 24'h000002; dat_i = 16'hABCD; sel_i = 2'b11; we_i = 1'b1; acc_i = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack_raw) acks++;
    end
    check("rstwr_no_ack", acks, 0);
    check("rstwr_idle_low", {31'd0, idle_o}, 32'd0);
    check("rstwr_dat_cleared", {16'd0, dat_raw}, 32'd0);
    acc_i = 1'b0;
    reset_n = 1'b1;
    access("rd_after_rst", 1'b0, 24'h000002, 16'h0000, 2'b00, 5);
    check("rstwr_word_unchanged", {16'd0, dat_raw}, 32'hFF34);

    // Refresh inhibited across 2500 cycles, then exactly one 7-cycle refresh.
    refresh_inhibit_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 2500; i++) begin
      step();
      if (!idle_o) acks++;
    end
    check("inhibit_never_busy", acks, 0);
    check("inhibit_rcount", {16'd0, refresh_count_o}, 32'd0);
    refresh_inhibit_i = 1'b0;
    step();
    check("refresh_start", {31'd0, idle_o}, 32'd0);
    n = 1;
    do begin
      step();
      if (!idle_o) n++;
    end while (!idle_o && n < 40);
    check("refresh_len", n, 7);
    check("refresh_rcount", {16'd0, refresh_count_o}, 32'd1);
    step();
    check("refresh_single", {31'd0, idle_o}, 32'd1);
    check("refresh_rcount_hold", {16'd0, refresh_count_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
